// File: rtl/calculator_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calculator_seq_if
// Purpose  : Request/response bundle for the sequential calculator. The
//            master issues operands and consumes results; the slave is the
//            calculator itself.
// Revision : 1.0 - initial release
// ============================================================================
interface calculator_seq_if #(
  parameter int NB = 48
);
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] a;
  logic [NB-1:0] b;
  logic [2:0]    operand;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] result;
  logic          ovf;
  logic          dz;
  logic          err;

  modport master (
    output in_valid, a, b, operand, out_ready,
    input  in_ready, out_valid, result, ovf, dz, err
  );

  modport slave (
    input  in_valid, a, b, operand, out_ready,
    output in_ready, out_valid, result, ovf, dz, err
  );
endinterface
`default_nettype wire

// File: rtl/calculator_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calculator_seq
// Purpose  : Signed NB-bit calculator. add/sub/illegal complete in one cycle;
//            mul (shift-add) and div/mod (restoring division) iterate over
//            NB cycles on operand magnitudes, then apply sign correction.
// Revision : 1.0 - initial release
// ============================================================================
module calculator_seq #(
  parameter int NB = 48
) (
  input  logic             clk,
  input  logic             rst,
  calculator_seq_if.slave  bus
);

  localparam int          CW     = $clog2(NB);
  localparam logic [2:0]  OP_ADD = 3'd0;
  localparam logic [2:0]  OP_SUB = 3'd1;
  localparam logic [2:0]  OP_MUL = 3'd2;
  localparam logic [2:0]  OP_DIV = 3'd3;
  localparam logic [2:0]  OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [NB-1:0]   result_q;
  logic            ovf_q;
  logic            dz_q;
  logic            err_q;

  // Captured request context for the iterative engine
  logic [2:0]      op_q;
  logic            sign_q;    // sign of quotient / product
  logic            sa_q;      // sign of a (remainder follows it)
  logic            bz_q;      // divisor was zero
  logic [CW-1:0]   cnt_q;

  // Engine datapath: z_q is the multiplier (mul) or the dividend/quotient (div)
  logic [2*NB-1:0] prod_q;
  logic [2*NB-1:0] mcand_q;
  logic [NB-1:0]   z_q;
  logic [NB-1:0]   rem_q;
  logic [NB-1:0]   magb_q;

  // Single-cycle operations and operand magnitudes
  logic [NB-1:0]   mag_a, mag_b, add_res, sub_res;
  logic            add_ovf, sub_ovf;
  assign mag_a   = bus.a[NB-1] ? -bus.a : bus.a;
  assign mag_b   = bus.b[NB-1] ? -bus.b : bus.b;
  assign add_res = bus.a + bus.b;
  assign sub_res = bus.a - bus.b;
  assign add_ovf = (bus.a[NB-1] == bus.b[NB-1]) && (add_res[NB-1] != bus.a[NB-1]);
  assign sub_ovf = (bus.a[NB-1] != bus.b[NB-1]) && (sub_res[NB-1] != bus.a[NB-1]);

  // One shift-add multiply step
  logic [2*NB-1:0] prod_d, mcand_d;
  logic [NB-1:0]   mpl_d;
  assign prod_d  = z_q[0] ? (prod_q + mcand_q) : prod_q;
  assign mcand_d = {mcand_q[2*NB-2:0], 1'b0};
  assign mpl_d   = {1'b0, z_q[NB-1:1]};

  // One restoring-division step; the partial remainder always stays below
  // 2*|b| <= 2^NB, so NB bits hold it after the trial subtraction.
  logic [NB:0]     shift;
  logic            ge;
  logic [NB-1:0]   trial, rem_d, quo_d;
  assign shift = {rem_q, z_q[NB-1]};
  assign ge    = (shift >= {1'b0, magb_q});
  assign trial = shift[NB-1:0] - magb_q;
  assign rem_d = ge ? trial : shift[NB-1:0];
  assign quo_d = {z_q[NB-2:0], ge};

  // Sign correction applied on the final step
  logic [2*NB-1:0] prod_s;
  logic [NB-1:0]   quo_s, rem_s;
  logic            mul_ovf, div_ovf;
  assign prod_s  = sign_q ? -prod_d : prod_d;
  assign mul_ovf = (|prod_s[2*NB-1:NB-1]) && !(&prod_s[2*NB-1:NB-1]);
  assign quo_s   = sign_q ? -quo_d : quo_d;
  // A positive quotient with the top bit set is only reachable as MIN / -1
  assign div_ovf = !sign_q && quo_d[NB-1];
  assign rem_s   = sa_q ? -rem_d : rem_d;

  // Control FSM, engine iteration and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= OP_ADD;
      sign_q      <= 1'b0;
      sa_q        <= 1'b0;
      bz_q        <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      z_q         <= '0;
      rem_q       <= '0;
      magb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            op_q       <= bus.operand;
            sign_q     <= bus.a[NB-1] ^ bus.b[NB-1];
            sa_q       <= bus.a[NB-1];
            bz_q       <= (bus.b == '0);
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
            err_q      <= 1'b0;
            case (bus.operand)
              OP_ADD: begin
                result_q    <= add_res;
                ovf_q       <= add_ovf;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              OP_SUB: begin
                result_q    <= sub_res;
                ovf_q       <= sub_ovf;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              OP_MUL: begin
                prod_q  <= '0;
                mcand_q <= {{NB{1'b0}}, mag_a};
                z_q     <= mag_b;
                state_q <= CALC;
              end
              OP_DIV, OP_MOD: begin
                rem_q   <= '0;
                z_q     <= mag_a;
                magb_q  <= mag_b;
                state_q <= CALC;
              end
              default: begin
                result_q    <= '0;
                err_q       <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            endcase
          end
        end

        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            z_q     <= mpl_d;
          end else begin
            rem_q <= rem_d;
            z_q   <= quo_d;
          end
          if (cnt_q == CW'(NB-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            if (op_q == OP_MUL) begin
              result_q <= prod_s[NB-1:0];
              ovf_q    <= mul_ovf;
            end else if (bz_q) begin
              result_q <= '0;
              dz_q     <= 1'b1;
            end else if (op_q == OP_DIV) begin
              result_q <= quo_s;
              ovf_q    <= div_ovf;
            end else begin
              result_q <= rem_s;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: doc/calculator_seq.md
CALCULATOR_SEQ -- requirements
Module: calculator_seq

Interface
REQ-001 The block SHALL have parameter NB, default 48, meaning operand/result width in bits; legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have ports a and b, input, NB bits each: signed two's-complement operands.
REQ-007 The block SHALL have port operand, input, 3 bits: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 illegal.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have port result, output, NB bits: signed result.
REQ-011 The block SHALL have ports ovf, dz and err, output, 1 bit each: signed overflow, divide-by-zero and illegal operand.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted when in_valid and in_ready are both 1; a, b and operand are captured on that edge and later input changes are ignored.
REQ-015 On accept, add, sub and illegal operands SHALL go IDLE->DONE, so out_valid rises on the edge after accept (latency 1).
REQ-016 On accept, mul, div and mod SHALL go IDLE->CALC and run an iterative engine of exactly NB cycles, then CALC->DONE (latency NB+1).
REQ-017 mul SHALL be a shift-add of operand magnitudes with sign correction; result = low NB bits of the full product; ovf=1 if the 2*NB-bit product is not representable in NB signed bits.
REQ-018 div and mod SHALL use restoring division of magnitudes; div truncates toward zero; mod takes the sign of a.
REQ-019 add and sub SHALL wrap modulo 2^NB, with ovf=1 on signed overflow.
REQ-020 When b=0 for div or mod, the block SHALL give result=0 and dz=1 at normal latency NB+1.
REQ-021 div of the most-negative value by -1 SHALL give result=most-negative and ovf=1; mod in that case SHALL give 0 and ovf=0.
REQ-022 An illegal operand SHALL give result=0 and err=1; ovf=0 and dz=0.
REQ-023 In DONE, out_valid SHALL be 1, and result and flags SHALL be held stable until out_ready=1.
REQ-024 The output handshake (out_valid and out_ready) SHALL move DONE->IDLE; in_ready returns one cycle later, with no same-cycle re-accept.
REQ-025 Flags not applicable to the operation SHALL be 0; all flags are valid only while out_valid=1.
REQ-026 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.

Reset
REQ-027 While rst=1, the block SHALL be in IDLE with in_ready=1, out_valid=0, result=0 and ovf=dz=err=0, asynchronously.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort the operation and discard the result; no out_valid follows.
REQ-029 After rst deasserts, the first request SHALL be accepted normally on the next edge with in_valid=1.

Verification
REQ-030 Scenario: NB=48, a=10, b=5, operand=0, out_ready=1 -> out_valid one cycle after accept, result=15, flags 0.
REQ-031 Scenario: a=7, b=3, operand=2 -> out_valid exactly 49 cycles after accept, result=21; then a=-7, b=2, operand=3 -> -3; operand=4 -> -1.
REQ-032 Scenario: a=20, b=0, operand=3 -> result=0, dz=1; a=9, b=9, operand=7 -> result=0, err=1 at latency 1.
REQ-033 Scenario: a=2^47-1, b=1, operand=0 -> result=-2^47, ovf=1; a=2^24, b=2^24, operand=2 -> ovf=1.
REQ-034 Scenario: hold out_ready=0 for 10 cycles in DONE -> out_valid, result and flags unchanged, in_ready=0, new in_valid ignored.
REQ-035 Scenario: rst pulse 20 cycles into a mul -> outputs at reset values immediately; next request a=2, b=3, operand=2 returns 6 with no stale result.
